// File: rtl/gpt_pkg.sv
// Shared types and encodings for the general-purpose timer time-base unit.
package gpt_pkg;

  typedef enum logic {
    CMS_EDGE   = 1'b0,
    CMS_CENTER = 1'b1
  } cms_e;

  typedef enum logic [1:0] {
    SM_OFF     = 2'd0,
    SM_RESET   = 2'd1,
    SM_GATED   = 2'd2,
    SM_TRIGGER = 2'd3
  } slave_mode_e;

  typedef enum logic [1:0] {
    UEV_NONE   = 2'd0,
    UEV_CNT    = 2'd1,
    UEV_REINIT = 2'd2
  } uev_src_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/gpt_prescaler.sv
// Prescaler with a PSC preload register; the active divider is only reloaded
// on an update event so a write never disturbs a running period.
module gpt_prescaler #(
  parameter int PSC_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 count_en_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic                 psc_we_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  output logic                 tick_o
);

  logic [PSC_WIDTH-1:0] psc_pre_q, psc_pre_d;
  logic [PSC_WIDTH-1:0] psc_act_q, psc_act_d;
  logic [PSC_WIDTH-1:0] pcnt_q, pcnt_d;

  always_comb begin
    psc_pre_d = psc_we_i ? psc_i : psc_pre_q;
    psc_act_d = load_i ? psc_pre_q : psc_act_q;
    tick_o    = count_en_i && !clear_i && (pcnt_q == psc_act_q);
    pcnt_d    = pcnt_q;
    if (clear_i) begin
      pcnt_d = '0;
    end else if (count_en_i) begin
      pcnt_d = tick_o ? '0 : pcnt_q + PSC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psc_pre_q <= '0;
      psc_act_q <= '0;
      pcnt_q    <= '0;
    end else begin
      psc_pre_q <= psc_pre_d;
      psc_act_q <= psc_act_d;
      pcnt_q    <= pcnt_d;
    end
  end

endmodule

// File: rtl/gpt_time_base_unit.sv
// Timer time base: auto-reload counter (edge up/down or center-aligned),
// repetition counter, ARR/RCR shadow registers and slave-mode control.
module gpt_time_base_unit
  import gpt_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int PSC_WIDTH = 16,
  parameter int RCR_WIDTH = 8
) (
  input  logic                 aclk_i,
  input  logic                 areset_i,
  input  logic                 cen_set_i,
  input  logic                 cen_clr_i,
  input  logic                 dir_i,
  input  logic                 cms_i,
  input  logic                 opm_i,
  input  logic                 arpe_i,
  input  logic                 udis_i,
  input  logic                 urs_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [CNT_WIDTH-1:0] arr_i,
  input  logic [RCR_WIDTH-1:0] rcr_i,
  input  logic                 psc_we_i,
  input  logic                 arr_we_i,
  input  logic                 rcr_we_i,
  input  logic                 ug_i,
  input  logic [1:0]           slave_mode_i,
  input  logic                 trgi_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 dir_o,
  output logic                 cen_o,
  output logic                 tick_o,
  output logic                 uev_o,
  output logic                 uif_set_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] arr_pre_q, arr_pre_d;
  logic [CNT_WIDTH-1:0] arr_act_q, arr_act_d;
  logic [RCR_WIDTH-1:0] rcr_pre_q, rcr_pre_d;
  logic [RCR_WIDTH-1:0] rcr_act_q, rcr_act_d;
  logic [RCR_WIDTH-1:0] rep_q, rep_d;
  logic                 dir_q, dir_d;
  logic                 cen_q, cen_d;
  logic                 tick_q, tick_d;
  logic                 uev_q, uev_d;
  logic                 uif_q, uif_d;
  cms_e                 mode_q, mode_d;

  slave_mode_e sm;
  cms_e        cms;
  uev_src_e    uev_src;
  logic        trg_reset, trg_start, reinit, count_en, tick;
  logic        wrap, cnt_uev, cur_dir;

  assign sm        = slave_mode_e'(slave_mode_i);
  assign cms       = cms_e'(cms_i);
  assign trg_reset = (sm == SM_RESET) && trgi_i;
  assign trg_start = (sm == SM_TRIGGER) && trgi_i;
  assign reinit    = ug_i || trg_reset;
  assign count_en  = cen_q && ((sm != SM_GATED) || trgi_i);

  gpt_prescaler #(
    .PSC_WIDTH(PSC_WIDTH)
  ) u_prescaler (
    .clk_i      (aclk_i),
    .rst_i      (areset_i),
    .count_en_i (count_en),
    .clear_i    (reinit),
    .load_i     (uev_src != UEV_NONE),
    .psc_we_i   (psc_we_i),
    .psc_i      (psc_i),
    .tick_o     (tick)
  );

  // mode_q remembers the mode of the last advance, so a switch into center
  // mode is only seen at the next tick and always begins counting up.
  always_comb begin
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    rep_d     = rep_q;
    arr_pre_d = arr_we_i ? arr_i : arr_pre_q;
    rcr_pre_d = rcr_we_i ? rcr_i : rcr_pre_q;
    arr_act_d = (arr_we_i && !arpe_i) ? arr_i : arr_act_q;
    rcr_act_d = rcr_act_q;
    wrap      = 1'b0;
    cnt_uev   = 1'b0;
    cur_dir   = DIR_UP;
    if (mode_q == CMS_EDGE) dir_d = dir_i;

    if (reinit) begin
      mode_d = cms;
      if (cms == CMS_CENTER) begin
        dir_d = DIR_UP;
        cnt_d = '0;
      end else begin
        dir_d = dir_i;
        cnt_d = (dir_i == DIR_DOWN) ? (arpe_i ? arr_pre_q : arr_act_d) : '0;
      end
    end else if (tick) begin
      mode_d = cms;
      if (cms == CMS_EDGE) dir_d = dir_i;
      if (arr_act_q == '0) begin
        cnt_d = '0;
      end else if (cms == CMS_EDGE) begin
        if (dir_i == DIR_UP) begin
          if (cnt_q == arr_act_q) begin
            cnt_d = '0;
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end else if (cnt_q == '0) begin
          cnt_d = arr_act_q;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end else begin
        cur_dir = (mode_q == CMS_CENTER) ? dir_q : DIR_UP;
        dir_d   = cur_dir;
        if (cur_dir == DIR_UP) begin
          if (cnt_q == arr_act_q) begin
            dir_d = DIR_DOWN;
            cnt_d = arr_act_q - CNT_WIDTH'(1);
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end else if (cnt_q == '0) begin
          dir_d = DIR_UP;
          cnt_d = CNT_WIDTH'(1);
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
    end

    if (wrap) begin
      if (rep_q == '0) begin
        cnt_uev = !udis_i;
        rep_d   = rcr_act_q;
      end else begin
        rep_d = rep_q - RCR_WIDTH'(1);
      end
    end

    if (reinit)       uev_src = UEV_REINIT;
    else if (cnt_uev) uev_src = UEV_CNT;
    else              uev_src = UEV_NONE;

    if (uev_src != UEV_NONE) begin
      rcr_act_d = rcr_pre_q;
      rep_d     = rcr_pre_q;
      if (arpe_i) arr_act_d = arr_pre_q;
    end
  end

  // Clear beats set; one-pulse mode stops the counter on its own update event.
  always_comb begin
    cen_d = cen_q;
    if (cen_set_i || trg_start) cen_d = 1'b1;
    if (cen_clr_i) cen_d = 1'b0;
    if (opm_i && cnt_uev) cen_d = 1'b0;
    tick_d = tick;
    uev_d  = (uev_src != UEV_NONE);
    uif_d  = (uev_src == UEV_CNT) || ((uev_src == UEV_REINIT) && !urs_i);
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      cnt_q     <= '0;
      arr_pre_q <= '1;
      arr_act_q <= '1;
      rcr_pre_q <= '0;
      rcr_act_q <= '0;
      rep_q     <= '0;
      dir_q     <= DIR_UP;
      mode_q    <= CMS_EDGE;
      cen_q     <= 1'b0;
      tick_q    <= 1'b0;
      uev_q     <= 1'b0;
      uif_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      arr_pre_q <= arr_pre_d;
      arr_act_q <= arr_act_d;
      rcr_pre_q <= rcr_pre_d;
      rcr_act_q <= rcr_act_d;
      rep_q     <= rep_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      cen_q     <= cen_d;
      tick_q    <= tick_d;
      uev_q     <= uev_d;
      uif_q     <= uif_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign dir_o     = dir_q;
  assign cen_o     = cen_q;
  assign tick_o    = tick_q;
  assign uev_o     = uev_q;
  assign uif_set_o = uif_q;

endmodule

// File: tb/tb_gpt_time_base_unit.sv
// Self-checking bench for gpt_time_base_unit: a vector table plus scripted
// multi-cycle scenarios, with per-cycle expectations checked through a queue.
module tb_gpt_time_base_unit;
  import gpt_pkg::*;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        areset = 1'b0, cen_set = 1'b0, cen_clr = 1'b0, dir = 1'b0;
  logic        cms = 1'b0, opm = 1'b0, arpe = 1'b0, udis = 1'b0, urs = 1'b0;
  logic        psc_we = 1'b0, arr_we = 1'b0, rcr_we = 1'b0, ug = 1'b0, trgi = 1'b0;
  logic [15:0] psc = '0;
  logic [31:0] arr = '0;
  logic [7:0]  rcr = '0;
  logic [1:0]  slave_mode = '0;
  logic [31:0] cnt_o;
  logic        dir_o, cen_o, tick_o, uev_o, uif_set_o;

  gpt_time_base_unit dut (
    .aclk_i       (aclk),
    .areset_i     (areset),
    .cen_set_i    (cen_set),
    .cen_clr_i    (cen_clr),
    .dir_i        (dir),
    .cms_i        (cms),
    .opm_i        (opm),
    .arpe_i       (arpe),
    .udis_i       (udis),
    .urs_i        (urs),
    .psc_i        (psc),
    .arr_i        (arr),
    .rcr_i        (rcr),
    .psc_we_i     (psc_we),
    .arr_we_i     (arr_we),
    .rcr_we_i     (rcr_we),
    .ug_i         (ug),
    .slave_mode_i (slave_mode),
    .trgi_i       (trgi),
    .cnt_o        (cnt_o),
    .dir_o        (dir_o),
    .cen_o        (cen_o),
    .tick_o       (tick_o),
    .uev_o        (uev_o),
    .uif_set_o    (uif_set_o)
  );

  typedef struct {
    logic        areset, cen_set, cen_clr, dir, cms, opm, arpe, udis, urs;
    logic        psc_we, arr_we, rcr_we, ug, trgi;
    logic [15:0] psc;
    logic [31:0] arr;
    logic [7:0]  rcr;
    logic [1:0]  slave_mode;
  } in_t;

  // mask bits: [5] cnt [4] dir [3] cen [2] tick [1] uev [0] uif
  typedef struct {
    string       name;
    logic [5:0]  mask;
    logic [31:0] cnt;
    logic [4:0]  flags;
  } exp_t;

  // ctl: {areset, cen_set, cen_clr, dir, urs, udis, ug, arr_we}
  // flags: {dir, cen, tick, uev, uif}
  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic [31:0] arr;
    logic [31:0] cnt;
    logic [4:0]  flags;
  } vec_t;

  in_t  cur;
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t ex(string name, logic [5:0] mask, logic [31:0] c, logic [4:0] f);
    exp_t e;
    e.name  = name;
    e.mask  = mask;
    e.cnt   = c;
    e.flags = f;
    return e;
  endfunction

  task automatic apply_stimulus(input exp_t e);
    @(negedge aclk);
    #1;
    areset = cur.areset; cen_set = cur.cen_set; cen_clr = cur.cen_clr;
    dir = cur.dir; cms = cur.cms; opm = cur.opm; arpe = cur.arpe;
    udis = cur.udis; urs = cur.urs; psc_we = cur.psc_we; psc = cur.psc;
    arr_we = cur.arr_we; arr = cur.arr; rcr_we = cur.rcr_we; rcr = cur.rcr;
    ug = cur.ug; slave_mode = cur.slave_mode; trgi = cur.trgi;
    exp_q.push_back(e);
    cur.areset = 1'b0; cur.cen_set = 1'b0; cur.cen_clr = 1'b0;
    cur.psc_we = 1'b0; cur.arr_we = 1'b0; cur.rcr_we = 1'b0; cur.ug = 1'b0;
  endtask

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s.%s: got %0h expected %0h", name, field, act, want);
    end
  endtask

  task automatic check_output(input exp_t e);
    if (e.mask[5]) cmp(e.name, "cnt", cnt_o, e.cnt);
    if (e.mask[4]) cmp(e.name, "dir", 32'(dir_o), 32'(e.flags[4]));
    if (e.mask[3]) cmp(e.name, "cen", 32'(cen_o), 32'(e.flags[3]));
    if (e.mask[2]) cmp(e.name, "tick", 32'(tick_o), 32'(e.flags[2]));
    if (e.mask[1]) cmp(e.name, "uev", 32'(uev_o), 32'(e.flags[1]));
    if (e.mask[0]) cmp(e.name, "uif", 32'(uif_set_o), 32'(e.flags[0]));
  endtask

  always @(negedge aclk) begin
    if (exp_q.size() > 0) check_output(exp_q.pop_front());
  end

  task automatic do_reset(input string name);
    cur = '{default: '0};
    cur.areset = 1'b1;
    apply_stimulus(ex(name, 6'b111111, 32'd0, 5'b00000));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: bench did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[14];
    logic [4:0] f;
    int c;
    logic tk, ue, dn;

    vecs[0]  = '{"rst",      8'b1000_0000, 32'd0, 32'd0, 5'b00000};
    vecs[1]  = '{"idle",     8'b0000_0000, 32'd0, 32'd0, 5'b00000};
    vecs[2]  = '{"arr7",     8'b0000_0001, 32'd7, 32'd0, 5'b00000};
    vecs[3]  = '{"ug_down",  8'b0001_0010, 32'd0, 32'd7, 5'b10011};
    vecs[4]  = '{"ug_urs",   8'b0000_1010, 32'd0, 32'd0, 5'b00010};
    vecs[5]  = '{"ug_udis",  8'b0000_0110, 32'd0, 32'd0, 5'b00011};
    vecs[6]  = '{"cen_set",  8'b0100_0000, 32'd0, 32'd0, 5'b01000};
    vecs[7]  = '{"set_clr",  8'b0110_0000, 32'd0, 32'd1, 5'b00100};
    vecs[8]  = '{"idle2",    8'b0000_0000, 32'd0, 32'd1, 5'b00000};
    vecs[9]  = '{"arr0_set", 8'b0100_0001, 32'd0, 32'd1, 5'b01000};
    vecs[10] = '{"frozen",   8'b0000_0000, 32'd0, 32'd0, 5'b01100};
    vecs[11] = '{"frozen2",  8'b0000_0000, 32'd0, 32'd0, 5'b01100};
    vecs[12] = '{"ug_arr0",  8'b0000_0010, 32'd0, 32'd0, 5'b01011};
    vecs[13] = '{"cen_clr",  8'b0010_0000, 32'd0, 32'd0, 5'b00100};

    cur = '{default: '0};
    for (int i = 0; i < 14; i++) begin
      cur.areset  = vecs[i].ctl[7];
      cur.cen_set = vecs[i].ctl[6];
      cur.cen_clr = vecs[i].ctl[5];
      cur.dir     = vecs[i].ctl[4];
      cur.urs     = vecs[i].ctl[3];
      cur.udis    = vecs[i].ctl[2];
      cur.ug      = vecs[i].ctl[1];
      cur.arr_we  = vecs[i].ctl[0];
      cur.arr     = vecs[i].arr;
      apply_stimulus(ex(vecs[i].name, 6'b111111, vecs[i].cnt, vecs[i].flags));
    end

    // Edge up, PSC=3, ARR=4: tick every 4 cycles, UEV every 20.
    do_reset("a_rst");
    cur.psc_we = 1'b1; cur.psc = 16'd3; cur.arr_we = 1'b1; cur.arr = 32'd4;
    apply_stimulus(ex("a_wr", 6'b100010, 32'd0, 5'b00000));
    cur.ug = 1'b1;
    apply_stimulus(ex("a_ug", 6'b100011, 32'd0, 5'b00011));
    cur.cen_set = 1'b1;
    apply_stimulus(ex("a_cen", 6'b101100, 32'd0, 5'b01000));
    for (int k = 1; k <= 40; k++) begin
      tk = (k % 4 == 0);
      ue = (k % 20 == 0);
      f  = {1'b0, 1'b1, tk, ue, ue};
      apply_stimulus(ex("a_run", 6'b101111, 32'((k / 4) % 5), f));
    end

    // Center aligned, ARR=5, RCR=1: triangle count, UEV every 10 ticks.
    do_reset("b_rst");
    cur.cms = 1'b1; cur.arr_we = 1'b1; cur.arr = 32'd5; cur.rcr_we = 1'b1; cur.rcr = 8'd1;
    apply_stimulus(ex("b_wr", 6'b100000, 32'd0, 5'b00000));
    cur.ug = 1'b1;
    apply_stimulus(ex("b_ug", 6'b110011, 32'd0, 5'b00011));
    cur.cen_set = 1'b1;
    apply_stimulus(ex("b_cen", 6'b111100, 32'd0, 5'b01000));
    for (int t = 1; t <= 40; t++) begin
      c  = t % 10;
      dn = (c == 0) || (c >= 6);
      ue = (t > 1) && (t % 10 == 1);
      if (c > 5) c = 10 - c;
      f = {dn, 1'b1, 1'b1, ue, ue};
      apply_stimulus(ex("b_run", 6'b111111, 32'(c), f));
    end

    // ARR preload enabled: new ARR applies only after the current period.
    do_reset("c1_rst");
    cur.arpe = 1'b1; cur.arr_we = 1'b1; cur.arr = 32'd4;
    apply_stimulus(ex("c1_wr", 6'b100000, 32'd0, 5'b00000));
    cur.ug = 1'b1;
    apply_stimulus(ex("c1_ug", 6'b100011, 32'd0, 5'b00011));
    cur.cen_set = 1'b1;
    apply_stimulus(ex("c1_cen", 6'b101000, 32'd0, 5'b01000));
    for (int t = 1; t <= 16; t++) begin
      if (t == 2) begin
        cur.arr_we = 1'b1; cur.arr = 32'd9;
      end
      c  = (t <= 5) ? (t % 5) : ((t - 5) % 10);
      ue = (t == 5) || (t == 15);
      f  = {1'b0, 1'b0, 1'b1, ue, ue};
      apply_stimulus(ex("c1_run", 6'b100111, 32'(c), f));
    end

    // ARR preload disabled: the same write stretches the running period.
    do_reset("c2_rst");
    cur.arr_we = 1'b1; cur.arr = 32'd4;
    apply_stimulus(ex("c2_wr", 6'b100000, 32'd0, 5'b00000));
    cur.ug = 1'b1;
    apply_stimulus(ex("c2_ug", 6'b100011, 32'd0, 5'b00011));
    cur.cen_set = 1'b1;
    apply_stimulus(ex("c2_cen", 6'b101000, 32'd0, 5'b01000));
    for (int t = 1; t <= 12; t++) begin
      if (t == 2) begin
        cur.arr_we = 1'b1; cur.arr = 32'd9;
      end
      ue = (t == 10);
      f  = {1'b0, 1'b0, 1'b1, ue, ue};
      apply_stimulus(ex("c2_run", 6'b100111, 32'(t % 10), f));
    end

    // One-pulse, edge down, ARR=3: stops with cen_o low at the UEV.
    do_reset("d_rst");
    cur.arr_we = 1'b1; cur.arr = 32'd3; cur.opm = 1'b1; cur.dir = 1'b1;
    apply_stimulus(ex("d_wr", 6'b010000, 32'd0, 5'b10000));
    cur.ug = 1'b1;
    apply_stimulus(ex("d_ug", 6'b110011, 32'd3, 5'b10011));
    cur.cen_set = 1'b1;
    apply_stimulus(ex("d_cen", 6'b101100, 32'd3, 5'b01000));
    for (int t = 1; t <= 3; t++) apply_stimulus(ex("d_run", 6'b101111, 32'(3 - t), 5'b01100));
    apply_stimulus(ex("d_stop", 6'b101111, 32'd3, 5'b00111));
    for (int t = 0; t < 2; t++) apply_stimulus(ex("d_hold", 6'b101111, 32'd3, 5'b00000));

    // URS/UDIS: software UG still raises UEV without UIF; overflows stay silent.
    do_reset("e_rst");
    cur.arr_we = 1'b1; cur.arr = 32'd2; cur.urs = 1'b1; cur.udis = 1'b1;
    apply_stimulus(ex("e_wr", 6'b100000, 32'd0, 5'b00000));
    cur.ug = 1'b1;
    apply_stimulus(ex("e_ug", 6'b100011, 32'd0, 5'b00010));
    cur.cen_set = 1'b1;
    apply_stimulus(ex("e_cen", 6'b101000, 32'd0, 5'b01000));
    for (int t = 1; t <= 10; t++) apply_stimulus(ex("e_run", 6'b100111, 32'(t % 3), 5'b00100));

    // Gated mode counts only while trgi_i is high.
    do_reset("f_rst");
    cur.slave_mode = SM_GATED; cur.cen_set = 1'b1;
    apply_stimulus(ex("f_cen", 6'b101100, 32'd0, 5'b01000));
    for (int t = 0; t < 3; t++) apply_stimulus(ex("f_gate_lo", 6'b101100, 32'd0, 5'b01000));
    cur.trgi = 1'b1;
    for (int t = 1; t <= 6; t++) apply_stimulus(ex("f_gate_hi", 6'b101100, 32'(t), 5'b01100));
    cur.trgi = 1'b0;
    for (int t = 0; t < 4; t++) apply_stimulus(ex("f_gate_off", 6'b101100, 32'd6, 5'b01000));
    cur.cen_clr = 1'b1;
    apply_stimulus(ex("f_clr", 6'b101100, 32'd6, 5'b00000));

    // Trigger mode: a trgi_i pulse starts the counter, cen_clr_i still wins.
    cur.slave_mode = SM_TRIGGER; cur.trgi = 1'b1;
    apply_stimulus(ex("g_trig", 6'b101100, 32'd6, 5'b01000));
    cur.trgi = 1'b0;
    apply_stimulus(ex("g_run", 6'b101100, 32'd7, 5'b01100));
    cur.trgi = 1'b1; cur.cen_clr = 1'b1;
    apply_stimulus(ex("g_trig_clr1", 6'b101100, 32'd8, 5'b00100));
    cur.trgi = 1'b0;
    apply_stimulus(ex("g_idle", 6'b101100, 32'd8, 5'b00000));
    cur.trgi = 1'b1; cur.cen_clr = 1'b1;
    apply_stimulus(ex("g_trig_clr0", 6'b101100, 32'd8, 5'b00000));
    cur.trgi = 1'b0;
    apply_stimulus(ex("g_idle2", 6'b101100, 32'd8, 5'b00000));

    // Reset mode: a trgi_i pulse reinitialises the counter and raises UEV.
    cur.slave_mode = SM_RESET; cur.cen_set = 1'b1;
    apply_stimulus(ex("h_cen", 6'b101111, 32'd8, 5'b01000));
    apply_stimulus(ex("h_run", 6'b101111, 32'd9, 5'b01100));
    apply_stimulus(ex("h_run", 6'b101111, 32'd10, 5'b01100));
    cur.trgi = 1'b1;
    apply_stimulus(ex("h_trig", 6'b101111, 32'd0, 5'b01011));
    cur.trgi = 1'b0;
    apply_stimulus(ex("h_after", 6'b101111, 32'd1, 5'b01100));

    repeat (2) @(negedge aclk);
    #1;
    cmp("drain", "pending", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
